// File: rtl/posit_add_pkg.sv
// posit_add_pkg: shared state type and width/scale/count helpers for the posit adder
package posit_add_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  function automatic int scale_width(input int n, input int es);
    return $clog2(n) + es + 2;
  endfunction
  function automatic int min_scale(input int n, input int es);
    return -((n - 2) << es);
  endfunction
  // Clamp the run length into 1..n-1 and convert it to a shift count.
  function automatic int sat_count(input int shift, input int n);
    int s;
    s = shift < 1 ? 1 : shift;
    s = s > n - 1 ? n - 1 : s;
    return s - 1;
  endfunction
endpackage

// File: rtl/posit_scale_sat_dec.sv
// posit_scale_sat_dec: combinational decrement of a signed scale, saturating at MIN_SCALE
module posit_scale_sat_dec #(
  parameter int EW = 8,
  parameter int MIN_SCALE = -48
) (
  input  logic signed [EW-1:0] i_exp,
  output logic signed [EW-1:0] o_exp,
  output logic                 o_underflow
);
  localparam logic signed [EW-1:0] MIN = EW'(MIN_SCALE);
  always_comb begin
    o_underflow = i_exp <= MIN;
    o_exp = o_underflow ? MIN : i_exp - EW'(1);
  end
endmodule

// File: rtl/posit_add_normalizer.sv
// posit_add_normalizer: serial left-shift normaliser; one shift and one scale decrement per cycle
module posit_add_normalizer import posit_add_pkg::*; #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N),
  parameter int EW = scale_width(N, ES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_mant,
  input  logic [RS:0]   in_shift,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_underflow
);
  state_t        r_state;
  logic          r_in_ready, r_out_valid, r_zero, r_uf;
  logic [N-1:0]  r_mant;
  logic [EW-1:0] r_exp, w_dec_exp;
  logic [RS:0]   r_cnt, w_c;
  logic          w_dec_uf, w_in_zero, w_direct;
  always_comb begin
    w_c       = (RS+1)'(sat_count(int'(in_shift), N));
    w_in_zero = in_mant == '0;
    w_direct  = w_in_zero || w_c == '0;
  end
  posit_scale_sat_dec #(.EW(EW), .MIN_SCALE(min_scale(N, ES))) u_dec (
    .i_exp(r_exp),
    .o_exp(w_dec_exp),
    .o_underflow(w_dec_uf)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_zero      <= 1'b0;
      r_uf        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_in_ready  <= 1'b0;
          r_mant      <= in_mant;
          r_exp       <= w_in_zero ? '0 : in_exp;
          r_zero      <= w_in_zero;
          r_uf        <= 1'b0;
          r_cnt       <= w_c;
          r_out_valid <= w_direct;
          r_state     <= w_direct ? HOLD : SHIFT;
        end
        SHIFT: begin
          r_mant <= r_mant << 1;
          r_exp  <= w_dec_exp;
          r_uf   <= r_uf | w_dec_uf;
          r_cnt  <= r_cnt - (RS+1)'(1);
          if (r_cnt == (RS+1)'(1)) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    in_ready      = r_in_ready;
    out_valid     = r_out_valid;
    out_mant      = r_mant;
    out_exp       = r_exp;
    out_zero      = r_zero;
    out_underflow = r_uf;
  end
endmodule

// File: tb/tb_posit_add_normalizer.sv
// tb_posit_add_normalizer: directed vectors with hand-computed results for the normaliser
module tb_posit_add_normalizer;
  logic       clk = 1'b0, reset = 1'b1;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [7:0] in_mant = '0, out_mant, in_exp = '0, out_exp;
  logic [3:0] in_shift = '0;
  logic       out_zero, out_underflow;
  int         n_chk = 0, n_fail = 0;
  posit_add_normalizer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_shift(in_shift), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_underflow(out_underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [7:0] m, input logic [3:0] s, input logic [7:0] e);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_mant = m; in_shift = s; in_exp = e; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_valid(input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, lat);
  endtask
  task automatic run_op(input logic [7:0] m, input logic [3:0] s, input logic [7:0] e, input int lat,
                        input logic [7:0] xm, input logic [7:0] xe, input logic xz, input logic xu);
    launch(m, s, e);
    wait_valid(lat);
    check("out_mant", out_mant, xm);
    check("out_exp", out_exp, xe);
    check("out_zero", out_zero, xz);
    check("out_underflow", out_underflow, xu);
    check("in_ready_busy", in_ready, 0);
    @(posedge clk);
    #1 check("valid_dropped", out_valid, 0);
  endtask
  initial begin
    logic [7:0] hm, he;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mant", out_mant, 0);
    check("rst_out_exp", out_exp, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_uf", out_underflow, 0);
    @(negedge clk) reset = 1'b0;
    run_op(8'b0001_0110, 4'd3, 8'd5, 2, 8'b0101_1000, 8'd3, 1'b0, 1'b0);
    run_op(8'b1110_1000, 4'd3, 8'd0, 2, 8'b1010_0000, 8'hFE, 1'b0, 1'b0);
    run_op(8'b0100_0000, 4'd1, 8'd7, 0, 8'b0100_0000, 8'd7, 1'b0, 1'b0);
    run_op(8'b0000_0001, 4'd7, 8'hD2, 6, 8'b0100_0000, 8'hD0, 1'b0, 1'b1);
    run_op(8'b0000_0000, 4'd7, 8'd9, 0, 8'b0000_0000, 8'd0, 1'b1, 1'b0);
    run_op(8'b0000_0001, 4'd12, 8'd10, 6, 8'b0100_0000, 8'd4, 1'b0, 1'b0);
    run_op(8'b0110_0000, 4'd0, 8'd3, 0, 8'b0110_0000, 8'd3, 1'b0, 1'b0);
    // Backpressure: hold the result while a competing operand waits upstream.
    out_ready = 1'b0;
    launch(8'b0010_1100, 4'd2, 8'd12);
    wait_valid(1);
    check("bp_mant", out_mant, 8'b0101_1000);
    check("bp_exp", out_exp, 8'd11);
    hm = out_mant; he = out_exp;
    in_mant = 8'hFF; in_shift = 4'd3; in_exp = 8'd1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_mant_stable", out_mant, hm);
      check("bp_exp_stable", out_exp, he);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_released", out_valid, 0);
    // Reset one cycle into a four-shift operand must discard it.
    launch(8'b0000_0011, 4'd5, 8'd20);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_mant", out_mant, 0);
    check("abort_exp", out_exp, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk) reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 check("abort_no_valid", out_valid, 0);
    end
    run_op(8'b1111_0101, 4'd4, 8'd0, 3, 8'b1010_1000, 8'hFD, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
